// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants for the MMIO board I/O block: register map, KCTRL layout
// and the debounce counter sizing helper.
package mmio_io_ctrl_pkg;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned SW_W   = 10;
    localparam int unsigned HEX_W  = 16;
    localparam int unsigned LEDR_W = 10;
    localparam int unsigned LEDG_W = 8;

    localparam int unsigned KCTRL_FLAG_LSB = 0;
    localparam int unsigned KCTRL_OVR_LSB  = 4;

    // Bits needed to count 0 .. cycles-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-bit 2-FF synchronizer plus hold-time debouncer, with a combinational
// pulse on the cycle a debounced bit is about to rise.
module io_debounce
    import mmio_io_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_deb,
    output logic [WIDTH-1:0] o_rise_c
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit fires once the synchronized value has differed for the full hold time.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fire[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_fire[i]) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign o_deb    = r_deb;
    assign o_rise_c = w_fire & r_sync2;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O: HEX/LEDR/LEDG output registers, debounced KEY/SW
// inputs and sticky key-press/overrun flags with write-1-to-clear.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    input  logic [KEY_W-1:0] KEY,
    input  logic [SW_W-1:0]  SW,
    output logic [HEX_W-1:0] hex,
    output logic [LEDR_W-1:0] ledr,
    output logic [LEDG_W-1:0] ledg
);

    logic [HEX_W-1:0]  r_hex;
    logic [LEDR_W-1:0] r_ledr;
    logic [LEDG_W-1:0] r_ledg;
    logic [KEY_W-1:0]  r_flag;
    logic [KEY_W-1:0]  r_ovr;

    logic [KEY_W-1:0]  w_key_pressed;
    logic [KEY_W-1:0]  w_key_deb;
    logic [KEY_W-1:0]  w_key_rise;
    logic [SW_W-1:0]   w_sw_deb;
    logic [SW_W-1:0]   w_sw_rise;
    logic [KEY_W-1:0]  w_clr_flag;
    logic [KEY_W-1:0]  w_clr_ovr;
    logic              w_hit_hex;
    logic              w_hit_ledr;
    logic              w_hit_ledg;
    logic              w_hit_key;
    logic              w_hit_sw;
    logic              w_hit_kctrl;
    logic              w_unused;

    assign w_key_pressed = ~KEY;

    io_debounce #(
        .WIDTH           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (w_key_pressed),
        .o_deb    (w_key_deb),
        .o_rise_c (w_key_rise)
    );

    io_debounce #(
        .WIDTH           (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (SW),
        .o_deb    (w_sw_deb),
        .o_rise_c (w_sw_rise)
    );

    // Word-granular decode; byte offset bits are ignored.
    assign w_hit_hex   = (addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2]);
    assign w_hit_ledr  = (addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]);
    assign w_hit_ledg  = (addr[DBITS-1:2] == ADDR_LEDG[DBITS-1:2]);
    assign w_hit_key   = (addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2]);
    assign w_hit_sw    = (addr[DBITS-1:2] == ADDR_SW[DBITS-1:2]);
    assign w_hit_kctrl = (addr[DBITS-1:2] == ADDR_KCTRL[DBITS-1:2]);

    always_comb begin
        sel   = 1'b0;
        rdata = '0;
        if (w_hit_hex) begin
            sel   = 1'b1;
            rdata = DBITS'(r_hex);
        end else if (w_hit_ledr) begin
            sel   = 1'b1;
            rdata = DBITS'(r_ledr);
        end else if (w_hit_ledg) begin
            sel   = 1'b1;
            rdata = DBITS'(r_ledg);
        end else if (w_hit_key) begin
            sel   = 1'b1;
            rdata = DBITS'(w_key_deb);
        end else if (w_hit_sw) begin
            sel   = 1'b1;
            rdata = DBITS'(w_sw_deb);
        end else if (w_hit_kctrl) begin
            sel   = 1'b1;
            rdata = DBITS'({r_ovr, r_flag});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex  <= '0;
            r_ledr <= '0;
            r_ledg <= '0;
        end else if (we) begin
            if (w_hit_hex)  r_hex  <= wdata[HEX_W-1:0];
            if (w_hit_ledr) r_ledr <= wdata[LEDR_W-1:0];
            if (w_hit_ledg) r_ledg <= wdata[LEDG_W-1:0];
        end
    end

    assign w_clr_flag = (we && w_hit_kctrl) ? wdata[KCTRL_FLAG_LSB +: KEY_W] : '0;
    assign w_clr_ovr  = (we && w_hit_kctrl) ? wdata[KCTRL_OVR_LSB  +: KEY_W] : '0;

    // A rise beats a same-cycle clear; overrun looks only at the pre-edge flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag <= '0;
            r_ovr  <= '0;
        end else begin
            r_flag <= w_key_rise | (r_flag & ~w_clr_flag);
            r_ovr  <= (w_key_rise & r_flag) | (r_ovr & ~w_clr_ovr);
        end
    end

    assign hex  = r_hex;
    assign ledr = r_ledr;
    assign ledg = r_ledg;

    assign w_unused = &{1'b0, wdata[DBITS-1:HEX_W], addr[1:0], w_sw_rise};

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: directed register/debounce/flag scenarios
// followed by randomized bus and input traffic against a reference model.
module tb_mmio_io_ctrl;
    import mmio_io_ctrl_pkg::*;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .DBITS           (32),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .sel   (sel),
        .rdata (rdata),
        .KEY   (KEY),
        .SW    (SW),
        .hex   (hex),
        .ledr  (ledr),
        .ledg  (ledg)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        exp_sel;
        logic [31:0] exp_rd;
        logic [15:0] exp_hex;
        logic [9:0]  exp_ledr;
        logic [7:0]  exp_ledg;
    } exp_t;

    exp_t sb_q[$];
    logic chk_strobe;
    int   n_checks;
    int   n_errors;

    // Reference model state
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kdeb, m_flag, m_ovr;
    logic [9:0]  m_sdeb;
    logic [3:0]  hk[$];
    logic [9:0]  hs[$];

    logic [3:0]  key_drv;
    logic [9:0]  sw_drv;

    function automatic logic hit(input logic [31:0] a, input logic [31:0] base);
        return a[31:2] == base[31:2];
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0;
        m_kdeb = '0; m_flag = '0; m_ovr = '0; m_sdeb = '0;
        hk.delete(); hs.delete();
        repeat (N + 2) begin
            hk.push_back(4'h0);
            hs.push_back(10'h0);
        end
    endtask

    function automatic void model_read(input logic [31:0] a, output logic s, output logic [31:0] r);
        s = 1'b1;
        if      (hit(a, ADDR_HEX))   r = {16'h0, m_hex};
        else if (hit(a, ADDR_LEDR))  r = {22'h0, m_ledr};
        else if (hit(a, ADDR_LEDG))  r = {24'h0, m_ledg};
        else if (hit(a, ADDR_KEY))   r = {28'h0, m_kdeb};
        else if (hit(a, ADDR_SW))    r = {22'h0, m_sdeb};
        else if (hit(a, ADDR_KCTRL)) r = {24'h0, m_ovr, m_flag};
        else begin
            s = 1'b0;
            r = '0;
        end
    endfunction

    // One clock edge of the model. A debounced bit follows the raw input once the
    // raw value sampled N consecutive edges ago (after 2 sync stages) disagrees with it.
    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] kp, input logic [9:0] sp);
        logic [3:0] k_new, rise, clrf, clro, ek;
        logic [9:0] s_new, es;
        logic       flip;
        hk.push_back(kp);
        hs.push_back(sp);
        if (hk.size() > N + 2) void'(hk.pop_front());
        if (hs.size() > N + 2) void'(hs.pop_front());
        k_new = m_kdeb;
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < N; j++) begin
                ek = hk[j];
                if (ek[i] == m_kdeb[i]) flip = 1'b0;
            end
            if (flip) k_new[i] = ~m_kdeb[i];
        end
        s_new = m_sdeb;
        for (int i = 0; i < 10; i++) begin
            flip = 1'b1;
            for (int j = 0; j < N; j++) begin
                es = hs[j];
                if (es[i] == m_sdeb[i]) flip = 1'b0;
            end
            if (flip) s_new[i] = ~m_sdeb[i];
        end
        rise = k_new & ~m_kdeb;
        clrf = '0;
        clro = '0;
        if (w) begin
            if (hit(a, ADDR_HEX))  m_hex  = d[15:0];
            if (hit(a, ADDR_LEDR)) m_ledr = d[9:0];
            if (hit(a, ADDR_LEDG)) m_ledg = d[7:0];
            if (hit(a, ADDR_KCTRL)) begin
                clrf = d[3:0];
                clro = d[7:4];
            end
        end
        m_ovr  = (rise & m_flag) | (m_ovr & ~clro);
        m_flag = rise | (m_flag & ~clrf);
        m_kdeb = k_new;
        m_sdeb = s_new;
    endtask

    // Drive one bus cycle; called #1 after a rising edge, returns #1 after the next.
    task automatic cycle(input string nm, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic chk);
        exp_t e;
        we = w; addr = a; wdata = d; KEY = key_drv; SW = sw_drv;
        if (chk) begin
            e.name = nm;
            e.a = a;
            model_read(a, e.exp_sel, e.exp_rd);
            e.exp_hex = m_hex; e.exp_ledr = m_ledr; e.exp_ledg = m_ledg;
            sb_q.push_back(e);
        end
        chk_strobe = chk;
        @(posedge clk);
        model_edge(w, a, d, ~key_drv, sw_drv);
        #1;
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        reset = 1'b1;
        we = 1'b0; addr = ADDR_KCTRL; wdata = '0;
        model_reset();
        #1;
        e.name = nm;
        e.a = ADDR_KCTRL;
        model_read(ADDR_KCTRL, e.exp_sel, e.exp_rd);
        e.exp_hex = m_hex; e.exp_ledr = m_ledr; e.exp_ledg = m_ledg;
        sb_q.push_back(e);
        chk_strobe = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_strobe = 1'b0;
    endtask

    // Monitor: compare the DUT's presented read and output registers away from the edge.
    always @(negedge clk) begin
        if (chk_strobe) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: strobe with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (sel !== e.exp_sel || rdata !== e.exp_rd) begin
                    n_errors++;
                    $display("FAIL %s rd@%h: got sel=%0b rdata=%h, want sel=%0b rdata=%h",
                             e.name, e.a, sel, rdata, e.exp_sel, e.exp_rd);
                end
                n_checks++;
                if (hex !== e.exp_hex || ledr !== e.exp_ledr || ledg !== e.exp_ledg) begin
                    n_errors++;
                    $display("FAIL %s outs: got hex=%h ledr=%h ledg=%h, want hex=%h ledr=%h ledg=%h",
                             e.name, hex, ledr, ledg, e.exp_hex, e.exp_ledr, e.exp_ledg);
                end
            end
        end
    end

    logic [31:0] alist [8];

    initial begin
        n_checks = 0; n_errors = 0;
        chk_strobe = 1'b0;
        key_drv = 4'hF; sw_drv = '0;
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; KEY = key_drv; SW = sw_drv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Warm-up traffic, then reset mid-run
        sw_drv = 10'h2A5;
        cycle("warm_hex", 1'b1, ADDR_HEX, 32'h1234_5678, 1'b1);
        cycle("warm_ledr", 1'b1, ADDR_LEDR, 32'h0000_0155, 1'b1);
        key_drv = 4'b0110;
        repeat (8) cycle("warm_key", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("warm_kctrl", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        key_drv = 4'b0111;
        cycle("warm_bounce", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        do_reset("rst_during");
        key_drv = 4'hF; sw_drv = '0;
        cycle("rst_key", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("rst_kctrl", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        repeat (8) cycle("rst_settle", 1'b0, ADDR_SW, 32'h0, 1'b1);

        // Output registers, including same-cycle readback of the old value
        cycle("wr_hex_old", 1'b1, ADDR_HEX, 32'hDEAD_BEEF, 1'b1);
        cycle("rd_hex", 1'b0, ADDR_HEX, 32'h0, 1'b1);
        cycle("wr_ledr", 1'b1, ADDR_LEDR, 32'h0000_03FF, 1'b1);
        cycle("wr_ledg", 1'b1, ADDR_LEDG, 32'h0000_01A5, 1'b1);
        cycle("rd_ledg", 1'b0, ADDR_LEDG, 32'h0, 1'b1);
        cycle("rd_ledr", 1'b0, ADDR_LEDR, 32'h0, 1'b1);

        // Short glitch on KEY[2] must not reach the debounced state
        key_drv = 4'b1011;
        repeat (3) cycle("glitch_key", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        key_drv = 4'hF;
        repeat (6) cycle("glitch_key_after", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("glitch_kctrl", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);

        // Held press: KEY reads 0x4 on the sixth cycle after the raw edge
        key_drv = 4'b1011;
        repeat (8) cycle("press_key", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("press_kctrl", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);

        // Release and re-press with flag still set -> overrun; then W1C
        key_drv = 4'hF;
        repeat (8) cycle("release", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        key_drv = 4'b1011;
        repeat (8) cycle("repress", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        cycle("clr_ovr", 1'b1, ADDR_KCTRL, 32'h0000_0040, 1'b1);
        cycle("after_clr_ovr", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        cycle("clr_flag", 1'b1, ADDR_KCTRL, 32'h0000_0004, 1'b1);
        cycle("after_clr_flag", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);

        // Clear of flag[0] on the exact cycle deb[0] rises: the rise wins
        key_drv = 4'b1010;
        cycle("sim_edge", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        repeat (4) cycle("sim_wait", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("sim_clear", 1'b1, ADDR_KCTRL, 32'h0000_0001, 1'b1);
        cycle("sim_after", 1'b0, ADDR_KCTRL, 32'h0, 1'b1);
        cycle("sim_key", 1'b0, ADDR_KEY, 32'h0, 1'b1);

        // Decode holes, read-only writes, byte-offset aliasing
        cycle("hole_0c", 1'b0, 32'hF000_000C, 32'h0, 1'b1);
        cycle("hole_18", 1'b0, 32'hF000_0018, 32'h0, 1'b1);
        cycle("wr_key_ro", 1'b1, ADDR_KEY, 32'h0000_000F, 1'b1);
        cycle("rd_key_ro", 1'b0, ADDR_KEY, 32'h0, 1'b1);
        cycle("alias_ledr", 1'b0, 32'hF000_0006, 32'h0, 1'b1);
        cycle("wr_hole", 1'b1, 32'hF000_000C, 32'hFFFF_FFFF, 1'b1);
        cycle("rd_after_hole", 1'b0, ADDR_HEX, 32'h0, 1'b1);

        // Randomized traffic
        alist[0] = ADDR_HEX;  alist[1] = ADDR_LEDR; alist[2] = ADDR_LEDG;
        alist[3] = ADDR_KEY;  alist[4] = ADDR_SW;   alist[5] = ADDR_KCTRL;
        alist[6] = 32'hF000_000C; alist[7] = 32'hF000_0100;
        for (int t = 0; t < 800; t++) begin
            logic [31:0] a;
            if (t == 400) begin
                do_reset("rnd_reset");
            end
            if ($urandom_range(0, 6) == 0) key_drv[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 6) == 0) sw_drv[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = alist[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            cycle("rnd", ($urandom_range(0, 2) == 0), a, $urandom(), 1'b1);
        end

        chk_strobe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O peripheral directly downstream of the single-cycle CPU data path; consumes the same store/load bus (address = ALU result, write data = rs2 value, write enable) that data memory does.
- Owns the board-facing registers (HEX, LEDR, LEDG), synchronizes and debounces KEY and SW, and latches sticky key-press flags that software polls and clears.
- Read data is muxed with data-memory read data by the CPU top when `sel` is high.

Parameters:
- DBITS, 32, bus data/address width
- DEBOUNCE_CYCLES, 500000, cycles a synchronized input must hold a new value before the debounced value follows (≥2; benches use 4)
- ADDR_HEX, 32'hF0000000, HEX register (RW, bits [15:0])
- ADDR_LEDR, 32'hF0000004, LEDR register (RW, bits [9:0])
- ADDR_LEDG, 32'hF0000008, LEDG register (RW, bits [7:0])
- ADDR_KEY, 32'hF0000010, debounced key state (RO, bits [3:0], 1 = pressed)
- ADDR_SW, 32'hF0000014, debounced switch state (RO, bits [9:0])
- ADDR_KCTRL, 32'hF0000110, key status (bits [3:0] sticky press flags, bits [7:4] overrun flags; write-1-to-clear)

Ports:
- clk  in  1  system clock (PLL output)
- reset  in  1  asynchronous, active-high reset
- we  in  1  store enable from controller
- addr  in  DBITS  byte address; bits [1:0] ignored
- wdata  in  DBITS  store data
- sel  out  1  combinational; 1 when addr[31:2] matches any of the six registers
- rdata  out  DBITS  combinational read of the addressed register, zero-extended; 0 when sel=0
- KEY  in  4  raw board keys, active-low, asynchronous
- SW  in  10  raw board switches, asynchronous
- hex  out  16  HEX digit nibbles to the four SevenSeg decoders
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

Behaviour:
- Reset (async, any time): hex=0, ledr=0, ledg=0, all flags 0, sync FFs and debounced KEY at "released" (pressed=0), SW sync/debounced 0, all debounce counters 0. Reset mid-bounce discards the counter.
- Input path per bit: invert KEY (pressed=1), then 2-FF synchronizer, then debouncer.
- Debouncer: counter increments each cycle while sync≠deb and clears to 0 whenever sync==deb. When sync≠deb and the counter equals DEBOUNCE_CYCLES-1, deb takes sync at the next edge and the counter clears.
- Latency: raw edge to deb change is exactly 2+DEBOUNCE_CYCLES cycles if the input is stable. A glitch shorter than DEBOUNCE_CYCLES never reaches deb.
- Press flag: set on the cycle deb[i] rises from 0 to 1.
- Overrun: if flag[i] is already 1 when a new rise occurs, overrun[i] is set.
- KCTRL write: writing a 1 to bit i clears that bit. A rise in the same cycle as a clear of the same bit wins, so the flag stays 1. Overrun is set only if the flag was 1 before that cycle.
- Register writes: with we=1 and addr hit, write takes effect at the next clk edge. HEX uses wdata[15:0], LEDR uses wdata[9:0], LEDG uses wdata[7:0]; upper bits are ignored.
- Writes to KEY or SW are ignored. Writes to unmapped addresses are ignored (sel=0).
- Reads: zero-latency combinational, with no side effects. A read in the same cycle as a write returns the old value.
- Outputs hex/ledr/ledg are direct register outputs, glitch-free.

Decomposition:
- Shared package holds: the six address constants, the KCTRL bit-field positions, and the $clog2-based counter-width function.
- One natural sub-module: io_debounce, a WIDTH-parameterized bank holding sync FFs, counters and deb state, with a rise-pulse output. It is instantiated twice: WIDTH=4 for KEY, WIDTH=10 for SW.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: assert reset mid-run, then release. Required: hex=0, ledr=0, ledg=0; read of 0xF0000010 returns 0; read of 0xF0000110 returns 0.
- Output registers: write 0xDEADBEEF to 0xF0000000, 0x3FF to 0xF0000004, 0x1A5 to 0xF0000008. Required: hex=16'hBEEF and ledr=10'h3FF at the next edge, ledg=8'hA5. A same-cycle readback returns the old value; the next cycle returns 0x0000BEEF.
- Debounce: drive KEY[2] low for 3 cycles and back high. Required: KEY reads 0 and KCTRL reads 0. Then hold KEY[2] low. Required: KEY reads 0x4 exactly 6 cycles after the raw edge, and KCTRL reads 0x04.
- Overrun and clear: with flag[2] set, release KEY[2] and press it again. Required: KCTRL reads 0x44. Write 0x40 to KCTRL. Required: reads 0x04. Write 0x04. Required: reads 0x00.
- Simultaneous clear and rise: time a KCTRL write of 0x01 to the cycle deb[0] rises, with flag[0] previously 0. Required: KCTRL reads 0x01, with overrun[0] still 0.
- Decode: read 0xF000000C and 0xF0000018. Required: sel=0, rdata=0. Write to 0xF0000010 with 0xF. Required: no state change. Read 0xF0000006. Required: aliases LEDR (bits [1:0] ignored).
